viterbi_frame_ctrl: RTL and testbench
=====================================

VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

Interface
REQ-001 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port start, input, 1 bit: frame start request, sampled only in IDLE.
REQ-004 SHALL have port frame_len, input, 10 bits: number of information symbols in the frame, captured with start.
REQ-005 SHALL have port sym_valid, input, 1 bit: upstream branch-metric set valid.
REQ-006 SHALL have port sym_ready, output, 1 bit: controller accepts a branch-metric set.
REQ-007 SHALL have port smu_clear, output, 1 bit: clears state metrics to zero in the state metric unit.
REQ-008 SHALL have port smu_enable, output, 1 bit: advances the state metric unit one trellis step.
REQ-009 SHALL have port tail_active, output, 1 bit: tells the branch-metric unit to force tail-bit (zero-input) metrics.
REQ-010 SHALL have port dec_wr_en, output, 1 bit: write strobe for the 8-bit decision vector into survivor memory.
REQ-011 SHALL have port dec_wr_addr, output, 10 bits: survivor memory address for the decision write.
REQ-012 SHALL have port tb_start, output, 1 bit: single-cycle traceback launch pulse.
REQ-013 SHALL have port tb_len, output, 10 bits: number of trellis steps to trace back.
REQ-014 SHALL have port tb_done, input, 1 bit: traceback unit finished.
REQ-015 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, INIT, RUN, FLUSH, TB.
REQ-017 IDLE: on start=1 with frame_len!=0, SHALL latch frame_len and go to INIT; start with frame_len==0 SHALL be ignored.
REQ-018 INIT: SHALL assert smu_clear for exactly one cycle, reset step counter to 0, then go to RUN.
REQ-019 RUN: sym_ready SHALL be 1; smu_enable SHALL equal sym_valid & sym_ready combinationally.
REQ-020 Each accepted step SHALL increment the 10-bit step counter; dec_wr_en SHALL pulse one cycle after each smu_enable with dec_wr_addr equal to that step's index.
REQ-021 When step index frame_len-1 is accepted, SHALL leave RUN next cycle (to FLUSH if tail enabled, else TB); sym_ready SHALL be 0 from that next cycle.
REQ-022 FLUSH: SHALL assert smu_enable and tail_active for exactly 3 consecutive cycles (K-1, K=4), each followed by a dec_wr_en write, counter continuing; then go to TB.
REQ-023 Counter SHALL wrap modulo 1024; a frame plus tail exceeding 1024 steps is a caller error, addresses wrap.
REQ-024 TB entry: SHALL pulse tb_start one cycle, issued the cycle after the last dec_wr_en; tb_len SHALL hold the total step count until IDLE.
REQ-025 TB: SHALL wait for tb_done=1, then go to IDLE; tb_done in any other state SHALL be ignored.
REQ-026 start while busy SHALL be ignored; frame_len changes after capture SHALL have no effect.
REQ-027 smu_enable and smu_clear SHALL never be high in the same cycle.

Reset
REQ-028 On rst=1, at any time including mid-frame, SHALL enter IDLE immediately; all outputs and counters 0.
REQ-029 A pending dec_wr_en or tb_start SHALL be suppressed by reset; no write after rst deasserts.

Configuration
REQ-030 With macro VITERBI_TAIL_FLUSH_EN defined, SHALL include FLUSH; tb_len = frame_len+3.
REQ-031 Without it, FLUSH SHALL be absent, tail_active tied 0, RUN goes straight to TB, tb_len = frame_len.

Structure
REQ-032 Shared package viterbi_pkg SHALL hold N_STATES=8, SM_W=7, BM_W=4, ADDR_W=10, K=4, TAIL_LEN=K-1, and the FSM state enum.
REQ-033 No sub-module; one FSM plus one step counter.

Verification
REQ-034 frame_len=5, sym_valid always 1, tail on -> smu_clear 1 cycle, 5 RUN enables, 3 tail enables, addrs 0..7, tb_start once, tb_len=8.
REQ-035 Same with tail off -> addrs 0..4, tb_len=5, tail_active never 1.
REQ-036 frame_len=4, sym_valid toggled 1,0,1,0 -> smu_enable only on valid cycles, addrs contiguous 0..3.
REQ-037 start with frame_len=0 -> busy stays 0, no outputs toggle.
REQ-038 rst after 2 accepted steps -> IDLE next edge, no further dec_wr_en, new start re-issues smu_clear and addr 0.
REQ-039 start and tb_done pulsed during RUN -> both ignored, frame completes normally.

Source files
------------

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis parameters and frame controller state encoding.
// FLUSH exists only when VITERBI_TAIL_FLUSH_EN is defined.
package viterbi_pkg;
   localparam int N_STATES = 8;
   localparam int SM_W     = 7;
   localparam int BM_W     = 4;
   localparam int ADDR_W   = 10;
   localparam int K        = 4;
   localparam int TAIL_LEN = K - 1;
   typedef enum logic [2:0] {
      IDLE,
      INIT,
      RUN,
`ifdef VITERBI_TAIL_FLUSH_EN
      FLUSH,
`endif
      TB
   } state_e;
endpackage

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: sequences clear, per-symbol ACS steps, optional tail flush and traceback.
// Tail flush (K-1 zero-input steps) is built only with VITERBI_TAIL_FLUSH_EN defined.
module viterbi_frame_ctrl
   import viterbi_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] frame_len,
   input  logic              sym_valid,
   output logic              sym_ready,
   output logic              smu_clear,
   output logic              smu_enable,
   output logic              tail_active,
   output logic              dec_wr_en,
   output logic [ADDR_W-1:0] dec_wr_addr,
   output logic              tb_start,
   output logic [ADDR_W-1:0] tb_len,
   input  logic              tb_done,
   output logic              busy
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic              tbs_q, tbs_d;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wr_d        = 1'b0;
      tbs_d       = 1'b0;
      sym_ready   = 1'b0;
      smu_clear   = 1'b0;
      smu_enable  = 1'b0;
      tail_active = 1'b0;
      case (state_q)
         IDLE: if (start && frame_len != '0) begin
            len_d   = frame_len;
            state_d = INIT;
         end
         INIT: begin
            smu_clear = 1'b1;
            cnt_d     = '0;
            state_d   = RUN;
         end
         RUN: begin
            sym_ready  = 1'b1;
            smu_enable = sym_valid;
`ifdef VITERBI_TAIL_FLUSH_EN
            if (sym_valid && cnt_q == len_q - ADDR_W'(1)) state_d = FLUSH;
`else
            if (sym_valid && cnt_q == len_q - ADDR_W'(1)) state_d = TB;
`endif
         end
`ifdef VITERBI_TAIL_FLUSH_EN
         FLUSH: begin
            smu_enable  = 1'b1;
            tail_active = 1'b1;
            if (cnt_q == len_q + ADDR_W'(TAIL_LEN - 1)) state_d = TB;
         end
`endif
         TB: begin
            // launch right after the final decision write; done is honoured only once launched
            tbs_d = wr_q;
            if (tb_done && !wr_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (smu_enable) begin
         cnt_d  = cnt_q + ADDR_W'(1);
         addr_d = cnt_q;
         wr_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         tbs_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         tbs_q   <= tbs_d;
      end
   end

   assign dec_wr_en   = wr_q;
   assign dec_wr_addr = addr_q;
   assign tb_start    = tbs_q;
   assign tb_len      = (state_q == TB) ? cnt_q : '0;
   assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: table-driven and randomized frame checks against a frame-level model.
module tb_viterbi_frame_ctrl;
`ifdef VITERBI_TAIL_FLUSH_EN
   localparam int TAIL = 3;
`else
   localparam int TAIL = 0;
`endif

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, sym_valid = 1'b0, tb_done = 1'b0;
   logic [9:0] frame_len = '0;
   logic       sym_ready, smu_clear, smu_enable, tail_active, dec_wr_en, tb_start, busy;
   logic [9:0] dec_wr_addr, tb_len;

   viterbi_frame_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .sym_valid(sym_valid),
      .sym_ready(sym_ready), .smu_clear(smu_clear), .smu_enable(smu_enable),
      .tail_active(tail_active), .dec_wr_en(dec_wr_en), .dec_wr_addr(dec_wr_addr),
      .tb_start(tb_start), .tb_len(tb_len), .tb_done(tb_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int n_clear, n_en, n_tail, n_tbs, viol;
   int addrs[$];
   logic [9:0] tbl_seen;
   logic prev_en = 1'b0, prev_wr = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      n_clear = 0; n_en = 0; n_tail = 0; n_tbs = 0; viol = 0; tbl_seen = '0;
      addrs.delete();
   endtask

   // frame-level observer: event counts, write addresses and cycle-relationship violations
   always @(negedge clk) begin
      if (rst) begin
         prev_en = 1'b0;
         prev_wr = 1'b0;
      end else begin
         if (smu_enable && smu_clear) viol++;
         if (sym_ready && smu_enable != sym_valid) viol++;
         if (smu_enable && !tail_active && !(sym_valid && sym_ready)) viol++;
         if (tail_active && !smu_enable) viol++;
         if (dec_wr_en != prev_en) viol++;
         if (tb_start && (!prev_wr || dec_wr_en)) viol++;
         if (dec_wr_en) addrs.push_back(int'(dec_wr_addr));
         if (smu_clear) n_clear++;
         if (smu_enable) n_en++;
         if (tail_active) n_tail++;
         if (tb_start) begin n_tbs++; tbl_seen = tb_len; end
         prev_en = smu_enable;
         prev_wr = dec_wr_en;
      end
   end

   // mode 0: valid always, 1: toggling 1,0,1,0..., 2: random
   task automatic run_frame(input string tag, input int len, input int mode, input bit inject,
                            input int exp_n, input int exp_tbl);
      int  cyc = 0;
      bit  got = 0;
      bit  bad = 0;
      int  busy_low = 0;
      clear_mon();
      start = 1'b1; frame_len = 10'(len);
      @(posedge clk); #1;
      start = 1'b0; frame_len = 10'($urandom);
      while (!got && cyc < 5000) begin
         sym_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
         start   = inject && cyc == 4;
         tb_done = inject && cyc == 4;
         if (inject && cyc == 4) frame_len = 10'd7;
         @(negedge clk);
         if (!busy) busy_low++;
         if (tb_start) got = 1;
         @(posedge clk); #1;
         cyc++;
      end
      sym_valid = 1'b0; start = 1'b0; tb_done = 1'b0;
      chk({tag, " tb_start_seen"}, int'(got), 1);
      repeat (2) @(posedge clk);
      #1;
      chk({tag, " tb_len_held"}, int'(tb_len), exp_tbl);
      tb_done = 1'b1;
      @(posedge clk); #1;
      tb_done = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, " idle_after_done"}, int'(busy), 0);
      chk({tag, " busy_during_frame"}, busy_low, 0);
      chk({tag, " clear_count"}, n_clear, 1);
      chk({tag, " enable_count"}, n_en, exp_n);
      chk({tag, " tail_count"}, n_tail, TAIL);
      chk({tag, " write_count"}, addrs.size(), exp_n);
      foreach (addrs[i]) if (addrs[i] != i % 1024) bad = 1;
      chk({tag, " addr_sequence_ok"}, int'(bad), 0);
      chk({tag, " tb_start_count"}, n_tbs, 1);
      chk({tag, " tb_len_at_start"}, int'(tbl_seen), exp_tbl);
      chk({tag, " protocol_violations"}, viol, 0);
   endtask

   typedef struct {
      int len;
      int mode;
      bit inject;
      int exp_n;
      int exp_tbl;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{5,    0, 1'b0, 5 + TAIL,    5 + TAIL};
      vecs[1] = '{4,    1, 1'b0, 4 + TAIL,    4 + TAIL};
      vecs[2] = '{1,    0, 1'b0, 1 + TAIL,    1 + TAIL};
      vecs[3] = '{20,   0, 1'b1, 20 + TAIL,   20 + TAIL};
      vecs[4] = '{12,   1, 1'b1, 12 + TAIL,   12 + TAIL};
      vecs[5] = '{1023, 0, 1'b0, 1023 + TAIL, (1023 + TAIL) % 1024};

      clear_mon();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs_zero",
          int'({sym_ready, smu_clear, smu_enable, tail_active, dec_wr_en, dec_wr_addr,
                tb_start, tb_len, busy}), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i])
         run_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].mode, vecs[i].inject,
                   vecs[i].exp_n, vecs[i].exp_tbl);

      for (int r = 0; r < 6; r++) begin
         int len = $urandom_range(1, 60);
         run_frame($sformatf("rand%0d", r), len, 2, r[0], len + TAIL, len + TAIL);
      end

      // zero-length start must not leave IDLE or wiggle any output
      begin
         int act = 0;
         clear_mon();
         start = 1'b1; frame_len = '0; sym_valid = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (5) begin
            @(negedge clk);
            if (busy || sym_ready || smu_clear || smu_enable || tail_active || dec_wr_en || tb_start) act++;
         end
         sym_valid = 1'b0;
         chk("zero_len_quiet_cycles", act, 0);
      end

      // reset mid-frame after two accepted steps
      begin
         int w = 0;
         clear_mon();
         start = 1'b1; frame_len = 10'd10;
         @(posedge clk); #1;
         start = 1'b0; sym_valid = 1'b1;
         while (addrs.size() < 2 && w < 50) begin
            @(negedge clk); #1;
            w++;
         end
         chk("rst_two_writes_reached", addrs.size(), 2);
         rst = 1'b1;
         #1;
         chk("rst_async_outputs_zero",
             int'({sym_ready, smu_clear, smu_enable, dec_wr_en, tb_start, tb_len, busy}), 0);
         @(negedge clk); #1;
         @(posedge clk); #1;
         rst = 1'b0;
         repeat (6) @(negedge clk);
         sym_valid = 1'b0;
         chk("rst_no_writes_after", addrs.size(), 2);
         chk("rst_stays_idle", int'(busy), 0);
         @(posedge clk); #1;
         run_frame("after_rst", 6, 0, 1'b0, 6 + TAIL, 6 + TAIL);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
